// File: rtl/zx_fdd_pkg.sv
// Shared encodings for the ZX<->FDD mailbox: status bit positions, port selects,
// strobe lane indices and the status-byte packer.
package zx_fdd_pkg;

  localparam int ST_RXAV   = 0;
  localparam int ST_TXF    = 1;
  localparam int ST_CNT_LO = 2;
  localparam int ST_UNF    = 5;
  localparam int ST_OVF    = 6;
  localparam int ST_DRQ    = 7;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_STAT = 1'b1;

  localparam int NUM_STB   = 4;
  localparam int STB_RD_ZX = 0;
  localparam int STB_WR_ZX = 1;
  localparam int STB_RD_FD = 2;
  localparam int STB_WR_FD = 3;

  typedef struct packed {
    logic ovf;
    logic unf;
  } sticky_t;

  function automatic logic [2:0] sat_cnt(input logic [31:0] c);
    return (c > 32'd7) ? 3'd7 : c[2:0];
  endfunction

  function automatic logic [7:0] pack_status(input logic avail, input logic full,
                                             input logic [2:0] cnt, input sticky_t fl,
                                             input logic drq);
    logic [7:0] s;
    s                       = '0;
    s[ST_RXAV]              = avail;
    s[ST_TXF]               = full;
    s[ST_CNT_LO+2:ST_CNT_LO] = cnt;
    s[ST_UNF]               = fl.unf;
    s[ST_OVF]               = fl.ovf;
    s[ST_DRQ]               = drq;
    return s;
  endfunction

endpackage

// File: rtl/zx_fdd_mailbox_fifo.sv
// Small synchronous FIFO used for each mailbox direction. A pop in the same cycle
// frees a slot, so a push into a full FIFO is still accepted then.
module mbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      CLK_16MHZ,
  input  logic                      nRESET,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DATA_W-1:0]         head,
  output logic                      ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW:0]   C_ONE = (PW+1)'(1);
  localparam logic [PW:0]   C_MAX = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == C_MAX);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & ~do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK_16MHZ) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK_16MHZ) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/zx_fdd_mailbox.sv
// ZX<->FDD mailbox: two FIFOs, async strobes synchronised into CLK_16MHZ.
// Each side's status byte and W1C flags describe the FIFO that side reads.
module zx_fdd_mailbox
  import zx_fdd_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] EMPTY_VAL   = {DATA_W{1'b1}}
) (
  input  logic              CLK_16MHZ,
  input  logic              nRESET,
  input  logic              ZX_IOSEL,
  input  logic              ZX_A0,
  input  logic              nRD,
  input  logic              nWR,
  input  logic [DATA_W-1:0] ZX_DIN,
  output logic [DATA_W-1:0] ZX_DOUT,
  output logic              ZX_DOE,
  input  logic              nTIIN,
  input  logic              nTIOUT,
  input  logic              FDD_A0,
  input  logic [DATA_W-1:0] FDD_DIN,
  output logic [DATA_W-1:0] FDD_DOUT,
  output logic              FDD_DOE,
  input  logic              WD1770_DRQ,
  output logic              IRQ_FDD
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Strobes are carried active-low so the synchronisers reset to the idle level
  logic [NUM_STB-1:0] stb_n, lvl_n, asrt, dsrt;

  assign stb_n[STB_RD_ZX] = ~(ZX_IOSEL & ~nRD);
  assign stb_n[STB_WR_ZX] = ~(ZX_IOSEL & ~nWR);
  assign stb_n[STB_RD_FD] = nTIIN;
  assign stb_n[STB_WR_FD] = nTIOUT;

  for (genvar g = 0; g < NUM_STB; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] sh_n;
    logic                   prv_n;
    always_ff @(posedge CLK_16MHZ) begin
      if (!nRESET) begin
        sh_n  <= '1;
        prv_n <= 1'b1;
      end else begin
        sh_n  <= {sh_n[SYNC_STAGES-2:0], stb_n[g]};
        prv_n <= sh_n[SYNC_STAGES-1];
      end
    end
    assign lvl_n[g] = sh_n[SYNC_STAGES-1];
    assign asrt[g]  = prv_n & ~sh_n[SYNC_STAGES-1];
    assign dsrt[g]  = ~prv_n & sh_n[SYNC_STAGES-1];
  end

  logic [SYNC_STAGES-1:0] drq_sh;
  logic                   drq_s;

  always_ff @(posedge CLK_16MHZ) begin
    if (!nRESET) drq_sh <= '0;
    else         drq_sh <= {drq_sh[SYNC_STAGES-2:0], WD1770_DRQ};
  end
  assign drq_s = drq_sh[SYNC_STAGES-1];

  // Address is long gone by the synchronised deassert edge, so hold it from assert
  logic zx_rsel, fd_rsel;

  always_ff @(posedge CLK_16MHZ) begin
    if (!nRESET) begin
      zx_rsel <= SEL_DATA;
      fd_rsel <= SEL_DATA;
    end else begin
      if (asrt[STB_RD_ZX]) zx_rsel <= ZX_A0;
      if (asrt[STB_RD_FD]) fd_rsel <= FDD_A0;
    end
  end

  logic zx_wr_data, zx_wr_stat, fd_wr_data, fd_wr_stat;
  logic pop_fz, pop_zf;

  assign zx_wr_data = asrt[STB_WR_ZX] & (ZX_A0 == SEL_DATA);
  assign zx_wr_stat = asrt[STB_WR_ZX] & (ZX_A0 == SEL_STAT);
  assign fd_wr_data = asrt[STB_WR_FD] & (FDD_A0 == SEL_DATA);
  assign fd_wr_stat = asrt[STB_WR_FD] & (FDD_A0 == SEL_STAT);
  assign pop_fz     = dsrt[STB_RD_ZX] & (zx_rsel == SEL_DATA);
  assign pop_zf     = dsrt[STB_RD_FD] & (fd_rsel == SEL_DATA);

  logic              zf_full, zf_empty, zf_ovf, fz_full, fz_empty, fz_ovf;
  logic [CW-1:0]     zf_cnt, fz_cnt;
  logic [DATA_W-1:0] zf_head, fz_head;

  mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_zf (
    .CLK_16MHZ (CLK_16MHZ),
    .nRESET    (nRESET),
    .push      (zx_wr_data),
    .pop       (pop_zf),
    .wdata     (ZX_DIN),
    .full      (zf_full),
    .empty     (zf_empty),
    .count     (zf_cnt),
    .head      (zf_head),
    .ovf       (zf_ovf)
  );

  mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fz (
    .CLK_16MHZ (CLK_16MHZ),
    .nRESET    (nRESET),
    .push      (fd_wr_data),
    .pop       (pop_fz),
    .wdata     (FDD_DIN),
    .full      (fz_full),
    .empty     (fz_empty),
    .count     (fz_cnt),
    .head      (fz_head),
    .ovf       (fz_ovf)
  );

  // Set terms are OR'd after the clear so a same-cycle event survives a W1C
  sticky_t fz_fl, zf_fl;

  always_ff @(posedge CLK_16MHZ) begin
    if (!nRESET) begin
      fz_fl <= '0;
      zf_fl <= '0;
    end else begin
      fz_fl.ovf <= (fz_fl.ovf & ~(zx_wr_stat & ZX_DIN[ST_OVF]))  | fz_ovf;
      fz_fl.unf <= (fz_fl.unf & ~(zx_wr_stat & ZX_DIN[ST_UNF]))  | (pop_fz & fz_empty);
      zf_fl.ovf <= (zf_fl.ovf & ~(fd_wr_stat & FDD_DIN[ST_OVF])) | zf_ovf;
      zf_fl.unf <= (zf_fl.unf & ~(fd_wr_stat & FDD_DIN[ST_UNF])) | (pop_zf & zf_empty);
    end
  end

  logic [DATA_W-1:0] zx_stat, fd_stat;

  assign zx_stat = DATA_W'(pack_status(~fz_empty, fz_full, sat_cnt(32'(fz_cnt)), fz_fl, 1'b0));
  assign fd_stat = DATA_W'(pack_status(~zf_empty, zf_full, sat_cnt(32'(zf_cnt)), zf_fl, drq_s));

  always_ff @(posedge CLK_16MHZ) begin
    if (!nRESET) begin
      ZX_DOUT  <= '0;
      FDD_DOUT <= '0;
    end else begin
      ZX_DOUT  <= (ZX_A0 == SEL_STAT)  ? zx_stat : (fz_empty ? EMPTY_VAL : fz_head);
      FDD_DOUT <= (FDD_A0 == SEL_STAT) ? fd_stat : (zf_empty ? EMPTY_VAL : zf_head);
    end
  end

  assign ZX_DOE  = ~lvl_n[STB_RD_ZX];
  assign FDD_DOE = ~lvl_n[STB_RD_FD];
  assign IRQ_FDD = ~zf_empty;

endmodule

// File: tb/tb_zx_fdd_mailbox.sv
// Directed bench for zx_fdd_mailbox: table of bus operations plus hand-written
// sequences for latency, same-cycle push/pop and mid-transfer reset.
module tb_zx_fdd_mailbox;

  logic       clk = 1'b0;
  logic       nRESET = 1'b0;
  logic       ZX_IOSEL = 1'b0, ZX_A0 = 1'b0, nRD = 1'b1, nWR = 1'b1;
  logic [7:0] ZX_DIN = '0, ZX_DOUT;
  logic       ZX_DOE;
  logic       nTIIN = 1'b1, nTIOUT = 1'b1, FDD_A0 = 1'b0;
  logic [7:0] FDD_DIN = '0, FDD_DOUT;
  logic       FDD_DOE, WD1770_DRQ = 1'b0, IRQ_FDD;

  int total = 0;
  int bad   = 0;
  int vidx  = 0;

  always #5 clk = ~clk;

  zx_fdd_mailbox dut (
    .CLK_16MHZ (clk),      .nRESET   (nRESET),
    .ZX_IOSEL  (ZX_IOSEL), .ZX_A0    (ZX_A0),
    .nRD       (nRD),      .nWR      (nWR),
    .ZX_DIN    (ZX_DIN),   .ZX_DOUT  (ZX_DOUT),  .ZX_DOE  (ZX_DOE),
    .nTIIN     (nTIIN),    .nTIOUT   (nTIOUT),   .FDD_A0  (FDD_A0),
    .FDD_DIN   (FDD_DIN),  .FDD_DOUT (FDD_DOUT), .FDD_DOE (FDD_DOE),
    .WD1770_DRQ(WD1770_DRQ), .IRQ_FDD(IRQ_FDD)
  );

  typedef struct packed {
    logic       side;  // 0 = ZX, 1 = FDD
    logic       wr;
    logic       a0;
    logic       drq;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  localparam logic ZX = 1'b0, FD = 1'b1, RD = 1'b0, WR = 1'b1, DAT = 1'b0, STA = 1'b1;

  vec_t tbl[$];
  logic [7:0] q[$];

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic to_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for DOE", nm);
  endtask

  task automatic wait_doe(input logic side, output bit to);
    int n = 0;
    while (!(side ? FDD_DOE : ZX_DOE) && n < 10) begin tick(1); n++; end
    to = (n >= 10);
  endtask

  task automatic add(input logic side, input logic wr, input logic a0, input logic drq,
                     input logic [7:0] din, input logic [7:0] exp);
    tbl.push_back('{side:side, wr:wr, a0:a0, drq:drq, din:din, exp:exp});
  endtask

  task automatic bus_op(input vec_t v, output logic [7:0] d, output bit to);
    d  = '0;
    to = 1'b0;
    tick(1);
    WD1770_DRQ = v.drq;
    if (v.side == ZX) begin
      ZX_IOSEL = 1'b1; ZX_A0 = v.a0; ZX_DIN = v.din;
      if (v.wr) nWR = 1'b0; else nRD = 1'b0;
    end else begin
      FDD_A0 = v.a0; FDD_DIN = v.din;
      if (v.wr) nTIOUT = 1'b0; else nTIIN = 1'b0;
    end
    if (v.wr) tick(4);
    else begin
      wait_doe(v.side, to);
      tick(1);
      d = v.side ? FDD_DOUT : ZX_DOUT;
    end
    nRD = 1'b1; nWR = 1'b1; nTIIN = 1'b1; nTIOUT = 1'b1; ZX_IOSEL = 1'b0;
    tick(5);
  endtask

  task automatic run_tbl();
    logic [7:0] d;
    bit         to;
    foreach (tbl[i]) begin
      bus_op(tbl[i], d, to);
      if (!tbl[i].wr) begin
        if (to) to_fail($sformatf("vec%0d", vidx));
        else    chk($sformatf("vec%0d", vidx), d, tbl[i].exp);
      end
      vidx++;
    end
    tbl.delete();
  endtask

  // FDD reads the head, then releases nTIIN in the same step that ZX drops nWR,
  // so the pop and the push land on the same clock edge.
  task automatic swap(input logic [7:0] w, input int k);
    bit to;
    tick(1);
    FDD_A0 = DAT; nTIIN = 1'b0;
    wait_doe(FD, to);
    tick(1);
    if (to) to_fail($sformatf("swap%0d", k));
    else    chk($sformatf("swap%0d_head", k), FDD_DOUT, q[0]);
    void'(q.pop_front());
    q.push_back(w);
    nTIIN = 1'b1; ZX_IOSEL = 1'b1; ZX_A0 = DAT; ZX_DIN = w; nWR = 1'b0;
    tick(4);
    nWR = 1'b1; ZX_IOSEL = 1'b0;
    tick(5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit to;
    // Reset state
    tick(3);
    chk("rst_zx_doe",  {7'd0, ZX_DOE},  8'h00);
    chk("rst_fdd_doe", {7'd0, FDD_DOE}, 8'h00);
    chk("rst_irq",     {7'd0, IRQ_FDD}, 8'h00);
    chk("rst_zx_dout", ZX_DOUT,  8'h00);
    chk("rst_fd_dout", FDD_DOUT, 8'h00);
    nRESET = 1'b1;
    tick(4);
    chk("post_rst_irq", {7'd0, IRQ_FDD}, 8'h00);

    add(ZX, RD, STA, 0, 8'h00, 8'h00);
    add(FD, RD, STA, 0, 8'h00, 8'h00);
    add(FD, RD, STA, 1, 8'h00, 8'h80);
    add(FD, RD, STA, 0, 8'h00, 8'h00);
    run_tbl();

    // IRQ_FDD rises SYNC_STAGES+1 edges after the write strobe
    tick(1);
    ZX_IOSEL = 1'b1; ZX_A0 = DAT; ZX_DIN = 8'hA5; nWR = 1'b0;
    tick(1); chk("irq_lat1", {7'd0, IRQ_FDD}, 8'h00);
    tick(1); chk("irq_lat2", {7'd0, IRQ_FDD}, 8'h00);
    tick(1); chk("irq_lat3", {7'd0, IRQ_FDD}, 8'h01);
    tick(2);
    nWR = 1'b1; ZX_IOSEL = 1'b0;
    tick(5);
    add(FD, RD, DAT, 0, 8'h00, 8'hA5);
    run_tbl();
    chk("irq_after_pop", {7'd0, IRQ_FDD}, 8'h00);

    // FDD overflow, drain, W1C, underflow
    add(FD, WR, DAT, 0, 8'h11, 8'h00);
    add(FD, WR, DAT, 0, 8'h22, 8'h00);
    add(FD, WR, DAT, 0, 8'h33, 8'h00);
    add(FD, WR, DAT, 0, 8'h44, 8'h00);
    add(FD, WR, DAT, 0, 8'h55, 8'h00);
    add(ZX, RD, STA, 0, 8'h00, 8'h53);
    add(FD, RD, STA, 0, 8'h00, 8'h00);
    add(ZX, RD, DAT, 0, 8'h00, 8'h11);
    add(ZX, RD, DAT, 0, 8'h00, 8'h22);
    add(ZX, RD, DAT, 0, 8'h00, 8'h33);
    add(ZX, RD, DAT, 0, 8'h00, 8'h44);
    add(ZX, RD, STA, 0, 8'h00, 8'h40);
    add(ZX, WR, STA, 0, 8'h40, 8'h00);
    add(ZX, RD, STA, 0, 8'h00, 8'h00);
    add(ZX, RD, DAT, 0, 8'h00, 8'hFF);
    add(ZX, RD, STA, 0, 8'h00, 8'h20);
    add(FD, WR, DAT, 0, 8'h66, 8'h00);
    add(ZX, RD, STA, 0, 8'h00, 8'h25);
    add(ZX, RD, DAT, 0, 8'h00, 8'h66);
    add(ZX, WR, STA, 0, 8'h20, 8'h00);
    add(ZX, RD, STA, 0, 8'h00, 8'h00);
    add(ZX, WR, DAT, 0, 8'h77, 8'h00);
    add(ZX, WR, DAT, 0, 8'h88, 8'h00);
    add(FD, RD, STA, 0, 8'h00, 8'h09);
    run_tbl();

    // Same-cycle push/pop on a 2-deep occupancy, wrapping the pointers
    q = '{8'h77, 8'h88};
    for (int i = 0; i < 10; i++) begin
      swap(8'hC0 + 8'(i), i);
      add(FD, RD, STA, 0, 8'h00, 8'h09);
      run_tbl();
    end

    // Full FIFO: a push alongside a pop is accepted, no OVF
    add(ZX, WR, DAT, 0, 8'hD0, 8'h00);
    add(ZX, WR, DAT, 0, 8'hD1, 8'h00);
    add(FD, RD, STA, 0, 8'h00, 8'h13);
    run_tbl();
    q.push_back(8'hD0);
    q.push_back(8'hD1);
    swap(8'hE0, 10);
    add(FD, RD, STA, 0, 8'h00, 8'h13);
    foreach (q[i]) add(FD, RD, DAT, 0, 8'h00, q[i]);
    add(FD, RD, STA, 0, 8'h00, 8'h00);
    run_tbl();
    q.delete();

    // Reset mid-transfer with both FIFOs holding 3 words
    for (int i = 0; i < 3; i++) begin
      add(ZX, WR, DAT, 0, 8'h31 + 8'(i), 8'h00);
      add(FD, WR, DAT, 0, 8'h41 + 8'(i), 8'h00);
    end
    add(FD, RD, STA, 0, 8'h00, 8'h0D);
    run_tbl();
    tick(1);
    FDD_A0 = DAT; nTIIN = 1'b0;
    wait_doe(FD, to);
    if (to) to_fail("rst_mid_doe");
    nRESET = 1'b0;
    tick(1);
    chk("rst_mid_fdd_doe", {7'd0, FDD_DOE}, 8'h00);
    chk("rst_mid_irq",     {7'd0, IRQ_FDD}, 8'h00);
    chk("rst_mid_fd_dout", FDD_DOUT, 8'h00);
    nTIIN = 1'b1;
    tick(2);
    nRESET = 1'b1;
    tick(5);
    chk("rst_rel_irq", {7'd0, IRQ_FDD}, 8'h00);
    add(ZX, RD, STA, 0, 8'h00, 8'h00);
    add(FD, RD, STA, 0, 8'h00, 8'h00);
    add(ZX, WR, DAT, 0, 8'h5A, 8'h00);
    add(FD, RD, DAT, 0, 8'h00, 8'h5A);
    add(FD, RD, STA, 0, 8'h00, 8'h00);
    run_tbl();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
